net_drive_resolver: RTL and testbench



---
 rtl/net_resolve_pkg.sv | 25 ++
 rtl/net_resolve_eval.sv | 31 +++
 rtl/net_drive_resolver.sv | 118 +++++++++++
 tb/tb_net_drive_resolver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/net_resolve_pkg.sv
// Shared types and defaults for the net drive resolver.
package net_resolve_pkg;

    localparam int unsigned DEF_NUM_DRV    = 4;
    localparam int unsigned DEF_CONT_LIMIT = 4;
    // Widest driver index the evaluation struct can carry (up to 256 drivers).
    localparam int unsigned IDX_MAX_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVEN  = 2'd1,
        ST_CONTEND = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Per-cycle evaluation of all drivers on the net.
    typedef struct packed {
        logic                 undriven;
        logic                 agree;
        logic                 contend;
        logic                 val;
        logic [IDX_MAX_W-1:0] idx;
    } eval_t;

endpackage

// File: rtl/net_resolve_eval.sv
// Combinational driver evaluation: lowest-index priority pick plus disagreement check.
module net_resolve_eval
    import net_resolve_pkg::*;
#(
    parameter int unsigned NUM_DRV = DEF_NUM_DRV
) (
    input  logic [NUM_DRV-1:0] drv_en,
    input  logic [NUM_DRV-1:0] drv_val,
    output eval_t              eval_c
);

    logic any_one;
    logic any_zero;

    // Lowest enabled index wins; disagreement means both a 1 and a 0 are driven.
    always_comb begin
        eval_c   = '0;
        any_one  = |(drv_en & drv_val);
        any_zero = |(drv_en & ~drv_val);
        for (int i = NUM_DRV - 1; i >= 0; i--) begin
            if (drv_en[i]) begin
                eval_c.idx = IDX_MAX_W'(i);
                eval_c.val = drv_val[i];
            end
        end
        eval_c.undriven = ~|drv_en;
        eval_c.contend  = any_one & any_zero;
        eval_c.agree    = (|drv_en) & ~(any_one & any_zero);
    end

endmodule

// File: rtl/net_drive_resolver.sv
// Resolves several drivers of one shared net into a single registered value,
// flags contention, counts contention cycles and latches a sticky fault.
// Build option: NET_RESOLVER_KEEPER_EN -- undriven cycles hold the last value
// (bus keeper) instead of pulling the net to 0.
module net_drive_resolver
    import net_resolve_pkg::*;
#(
    parameter int unsigned NUM_DRV    = DEF_NUM_DRV,
    parameter int unsigned CONT_LIMIT = DEF_CONT_LIMIT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_DRV-1:0]         drv_en,
    input  logic [NUM_DRV-1:0]         drv_val,
    input  logic                       clr,
    output logic                       net_val,
    output logic                       net_z,
    output logic                       contention,
    output logic                       fault,
    output logic [CNT_W-1:0]           cont_cnt,
    output logic [$clog2(NUM_DRV)-1:0] win_idx
);

    localparam int unsigned IDX_W  = $clog2(NUM_DRV);
    localparam int unsigned CONS_W = $clog2(CONT_LIMIT + 1);

    eval_t             ev;
    state_t            state_q, state_d;
    logic [CONS_W-1:0] cons_q, cons_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              net_val_d;
    logic [IDX_W-1:0]  win_idx_d;
    logic              unused_idx;

    net_resolve_eval #(
        .NUM_DRV (NUM_DRV)
    ) u_eval (
        .drv_en  (drv_en),
        .drv_val (drv_val),
        .eval_c  (ev)
    );

    // Upper index bits are zero for small driver counts.
    assign unused_idx = ^ev.idx;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cons_q     <= '0;
            cont_cnt   <= '0;
            net_val    <= 1'b0;
            net_z      <= 1'b1;
            contention <= 1'b0;
            fault      <= 1'b0;
            win_idx    <= '0;
        end else begin
            state_q    <= state_d;
            cons_q     <= cons_d;
            cont_cnt   <= cnt_d;
            net_val    <= net_val_d;
            net_z      <= ev.undriven;
            contention <= ev.contend;
            fault      <= (state_d == ST_FAULT);
            win_idx    <= win_idx_d;
        end
    end

    // Next state, counters and resolved value.
    always_comb begin
        state_d   = state_q;
        cons_d    = cons_q;
        cnt_d     = cont_cnt;
        net_val_d = ev.val;
        win_idx_d = ev.idx[IDX_W-1:0];

        if (ev.undriven) begin
            win_idx_d = win_idx;
`ifdef NET_RESOLVER_KEEPER_EN
            net_val_d = net_val;
`else
            net_val_d = 1'b0;
`endif
        end

        // Counters: clr beats a same-cycle contention.
        if (clr) begin
            cons_d = '0;
            cnt_d  = '0;
        end else if (ev.contend) begin
            if (cons_q != CONS_W'(CONT_LIMIT)) begin
                cons_d = cons_q + CONS_W'(1);
            end
            if (cont_cnt != {CNT_W{1'b1}}) begin
                cnt_d = cont_cnt + CNT_W'(1);
            end
        end else begin
            cons_d = '0;
        end

        // FAULT is sticky until clr; otherwise track the current evaluation.
        if (state_q == ST_FAULT && !clr) begin
            state_d = ST_FAULT;
        end else if (ev.contend) begin
            if (!clr && cons_q >= CONS_W'(CONT_LIMIT - 1)) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_CONTEND;
            end
        end else if (ev.agree) begin
            state_d = ST_DRIVEN;
        end else begin
            state_d = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_net_drive_resolver.sv
// Self-checking bench for net_drive_resolver: directed scenarios plus random
// traffic checked against a rule-level reference model.
module tb_net_drive_resolver;

    localparam int NUM_DRV    = 4;
    localparam int CONT_LIMIT = 4;
    localparam int CNT_W      = 5;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_DRV-1:0] drv_en;
    logic [NUM_DRV-1:0] drv_val;
    logic               clr;
    logic               net_val;
    logic               net_z;
    logic               contention;
    logic               fault;
    logic [CNT_W-1:0]   cont_cnt;
    logic [1:0]         win_idx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic m_val;
    logic m_z;
    logic m_cont;
    logic m_fault;
    int   m_cnt;
    int   m_idx;
    int   m_consec;

    net_drive_resolver #(
        .NUM_DRV    (NUM_DRV),
        .CONT_LIMIT (CONT_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drv_en     (drv_en),
        .drv_val    (drv_val),
        .clr        (clr),
        .net_val    (net_val),
        .net_z      (net_z),
        .contention (contention),
        .fault      (fault),
        .cont_cnt   (cont_cnt),
        .win_idx    (win_idx)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic [NUM_DRV-1:0] en, input logic [NUM_DRV-1:0] val,
                        input logic c, input logic r);
        int  first;
        bit  disagree;
        drv_en  = en;
        drv_val = val;
        clr     = c;
        rst     = r;
        @(posedge clk);
        if (r) begin
            m_val = 0; m_z = 1; m_cont = 0; m_fault = 0;
            m_cnt = 0; m_idx = 0; m_consec = 0;
        end else begin
            first    = -1;
            disagree = 0;
            for (int i = 0; i < NUM_DRV; i++) begin
                if (en[i]) begin
                    if (first < 0) first = i;
                    else if (val[i] != val[first]) disagree = 1;
                end
            end
            if (first < 0) begin
                m_z = 1;
`ifndef NET_RESOLVER_KEEPER_EN
                m_val = 0;
`endif
            end else begin
                m_z   = 0;
                m_val = val[first];
                m_idx = first;
            end
            m_cont = disagree;
            if (c) begin
                m_cnt = 0; m_consec = 0; m_fault = 0;
            end else if (disagree) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_consec < CONT_LIMIT) m_consec++;
                if (m_consec >= CONT_LIMIT) m_fault = 1;
            end else begin
                m_consec = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 4'($urandom), 1'b0, 1'b0);
            total++; if (net_z !== 1'b1) begin bad++; $display("FAIL reset_net_z got=%b exp=1", net_z); end
            total++; if (net_val !== 1'b0) begin bad++; $display("FAIL reset_net_val got=%b exp=0", net_val); end
            total++; if (contention !== 1'b0) begin bad++; $display("FAIL reset_contention got=%b exp=0", contention); end
            total++; if (cont_cnt !== '0) begin bad++; $display("FAIL reset_cont_cnt got=%0d exp=0", cont_cnt); end
            total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
            total++; if (win_idx !== 2'd0) begin bad++; $display("FAIL reset_win_idx got=%0d exp=0", win_idx); end
        end
    endtask

    task automatic test_agreement();
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        total++; if (net_val !== 1'b0) begin bad++; $display("FAIL agree0_net_val got=%b exp=0", net_val); end
        total++; if (contention !== 1'b0) begin bad++; $display("FAIL agree0_contention got=%b exp=0", contention); end
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        total++; if (net_val !== 1'b1) begin bad++; $display("FAIL agree1_net_val got=%b exp=1", net_val); end
        total++; if (contention !== 1'b0) begin bad++; $display("FAIL agree1_contention got=%b exp=0", contention); end
        total++; if (win_idx !== 2'd0) begin bad++; $display("FAIL agree1_win_idx got=%0d exp=0", win_idx); end
        total++; if (net_z !== 1'b0) begin bad++; $display("FAIL agree1_net_z got=%b exp=0", net_z); end
    endtask

    task automatic test_fault();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(4'b0110, 4'b0010, 1'b0, 1'b0);
            total++; if (net_val !== 1'b1) begin bad++; $display("FAIL fault_net_val cyc=%0d got=%b exp=1", k, net_val); end
            total++; if (win_idx !== 2'd1) begin bad++; $display("FAIL fault_win_idx cyc=%0d got=%0d exp=1", k, win_idx); end
            total++; if (contention !== 1'b1) begin bad++; $display("FAIL fault_contention cyc=%0d got=%b exp=1", k, contention); end
            total++; if (fault !== (k == 4)) begin bad++; $display("FAIL fault_fault cyc=%0d got=%b exp=%b", k, fault, k == 4); end
            total++; if (cont_cnt !== CNT_W'(k)) begin bad++; $display("FAIL fault_cont_cnt cyc=%0d got=%0d exp=%0d", k, cont_cnt, k); end
        end
        // Fault is sticky through a non-contention cycle.
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b exp=1", fault); end
        total++; if (net_val !== 1'b1) begin bad++; $display("FAIL fault_resolving got=%b exp=1", net_val); end
    endtask

    task automatic test_interrupted();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0110, 4'b0010, 1'b0, 1'b0);
        step(4'b0110, 4'b0110, 1'b0, 1'b0);
        total++; if (contention !== 1'b0) begin bad++; $display("FAIL interrupt_agree got=%b exp=0", contention); end
        for (int k = 0; k < 3; k++) begin
            step(4'b0110, 4'b0010, 1'b0, 1'b0);
            total++; if (fault !== 1'b0) begin bad++; $display("FAIL interrupt_fault got=%b exp=0", fault); end
        end
        total++; if (cont_cnt !== CNT_W'(6)) begin bad++; $display("FAIL interrupt_cont_cnt got=%0d exp=6", cont_cnt); end
    endtask

    task automatic test_clr();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(4'b1100, 4'b1000, 1'b0, 1'b0);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL clr_pre_fault got=%b exp=1", fault); end
        step(4'b1100, 4'b1000, 1'b1, 1'b0);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL clr_fault got=%b exp=0", fault); end
        total++; if (cont_cnt !== '0) begin bad++; $display("FAIL clr_cont_cnt got=%0d exp=0", cont_cnt); end
        step(4'b1100, 4'b1000, 1'b0, 1'b0);
        total++; if (cont_cnt !== CNT_W'(1)) begin bad++; $display("FAIL clr_next_cnt got=%0d exp=1", cont_cnt); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL clr_next_fault got=%b exp=0", fault); end
        total++; if (win_idx !== 2'd2) begin bad++; $display("FAIL clr_win_idx got=%0d exp=2", win_idx); end
    endtask

    task automatic test_keeper();
        logic exp_v;
`ifdef NET_RESOLVER_KEEPER_EN
        exp_v = 1'b1;
`else
        exp_v = 1'b0;
`endif
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        total++; if (net_val !== 1'b1) begin bad++; $display("FAIL keeper_drive got=%b exp=1", net_val); end
        step(4'b0000, 4'b1010, 1'b0, 1'b0);
        total++; if (net_val !== exp_v) begin bad++; $display("FAIL keeper_net_val got=%b exp=%b", net_val, exp_v); end
        total++; if (net_z !== 1'b1) begin bad++; $display("FAIL keeper_net_z got=%b exp=1", net_z); end
        total++; if (win_idx !== 2'd0) begin bad++; $display("FAIL keeper_win_hold got=%0d exp=0", win_idx); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) step(4'b0011, 4'b0010, 1'b0, 1'b0);
        step(4'b0011, 4'b0010, 1'b0, 1'b1);
        total++; if (contention !== 1'b0) begin bad++; $display("FAIL rstmid_contention got=%b exp=0", contention); end
        for (int k = 0; k < 3; k++) step(4'b0011, 4'b0010, 1'b0, 1'b0);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rstmid_fault got=%b exp=0", fault); end
        total++; if (cont_cnt !== CNT_W'(3)) begin bad++; $display("FAIL rstmid_cont_cnt got=%0d exp=3", cont_cnt); end
    endtask

    task automatic test_saturation();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < CNT_MAX + 8; k++) step(4'b1001, 4'b0001, 1'b0, 1'b0);
        total++; if (cont_cnt !== CNT_W'(CNT_MAX)) begin bad++; $display("FAIL sat_cont_cnt got=%0d exp=%0d", cont_cnt, CNT_MAX); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL sat_fault got=%b exp=1", fault); end
    endtask

    task automatic test_random();
        logic [NUM_DRV-1:0] en;
        logic [NUM_DRV-1:0] val;
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            en  = 4'($urandom);
            val = 4'($urandom);
            // Bias towards long contention runs so fault and saturation are reached.
            if ($urandom_range(0, 2) != 0) begin en = 4'b0101; val = 4'b0100; end
            step(en, val, $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
            total++; if (net_val !== m_val) begin bad++; $display("FAIL rnd_net_val cyc=%0d got=%b exp=%b", k, net_val, m_val); end
            total++; if (net_z !== m_z) begin bad++; $display("FAIL rnd_net_z cyc=%0d got=%b exp=%b", k, net_z, m_z); end
            total++; if (contention !== m_cont) begin bad++; $display("FAIL rnd_contention cyc=%0d got=%b exp=%b", k, contention, m_cont); end
            total++; if (fault !== m_fault) begin bad++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", k, fault, m_fault); end
            total++; if (cont_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_cont_cnt cyc=%0d got=%0d exp=%0d", k, cont_cnt, m_cnt); end
            total++; if (win_idx !== 2'(m_idx)) begin bad++; $display("FAIL rnd_win_idx cyc=%0d got=%0d exp=%0d", k, win_idx, m_idx); end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; drv_en = '0; drv_val = '0;
        test_reset();
        test_agreement();
        test_fault();
        test_interrupted();
        test_clr();
        test_keeper();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
